risc_v_multicycle_controller: RTL and testbench
===============================================

# risc_v_multicycle_controller

Control unit for the multi-cycle RISC-V datapath. It decodes `op`, `func3` and `func7` from the instruction register and sequences every instruction through a Moore state machine. It samples the ALU flags `zero` and `neg` for branches. It drives all datapath enables and mux selects, so it is the control end of the datapath's control/status interface. It is paired 1:1 with the datapath at the core top level.

## Interface
No parameters.
- `clk` input 1: core clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `op` input 7: instr[6:0].
- `func3` input 3: instr[14:12].
- `func7` input 1: instr[30].
- `zero` input 1: ALU result == 0 (combinational, same cycle).
- `neg` input 1: ALU result bit 31 (combinational, same cycle).
- `PCWrite` output 1: PC register load.
- `adrSrc` output 1: memory address select; 0 = PC, 1 = Result.
- `memWrite` output 1: data memory write.
- `IRWrite` output 1: loads IR and OldPC.
- `regWrite` output 1: register file write to rd.
- `resultSrc` output 2: Result select; 00 = ALUOut, 01 = MDR, 10 = ALUResult, 11 = ImmExt.
- `ALUSrcA` output 2: ALU A select; 00 = PC, 01 = OldPC, 10 = A, 11 = 0.
- `ALUSrcB` output 2: ALU B select; 00 = B, 01 = ImmExt, 10 = 4, 11 = 0.
- `ALUControl` output 3: 000 = ADD, 001 = SUB, 010 = AND, 011 = OR, 100 = SLT, 101 = XOR.
- `immSrc` output 3: 000 = I, 001 = S, 010 = B, 011 = U, 100 = J.
- `illegal` output 1: one-cycle pulse in DECODE when the opcode or func3 is unsupported.

## Operation
- All outputs are decoded from the state register only (Moore).
- Exception: `immSrc` is decoded combinationally from `op` in every state.
- Exception: `PCWrite` in BRANCH additionally depends on the flags.
- Unlisted outputs in a state are 0: enables 0, selects 00, ALUControl ADD.
- `immSrc` by opcode: jalr/lw/I-ALU → I; sw → S; branch → B; lui → U; jal → J; other → I.

States and actions:
- FETCH: adrSrc=0, IRWrite=1, A=PC, B=4, ADD, resultSrc=10, PCWrite=1. Next: DECODE.
- DECODE: A=OldPC, B=Imm, ADD (ALUOut ← branch/jal target). Next state by `op`:
  - 0110011 → EX_R
  - 0010011 → EX_I
  - 0000011 or 0100011 → MEM_ADR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - else, or illegal func3 → FETCH with `illegal`=1.
- EX_R: A=A, B=B. ALUControl from {func7, func3}:
  - {0,000} ADD, {1,000} SUB, 111 AND, 110 OR, 010 SLT, 100 XOR.
  - Other func3 values are flagged illegal in DECODE.
  - Next: ALU_WB.
- EX_I: A=A, B=Imm, same func3 map with func7 ignored. Next: ALU_WB.
- ALU_WB: resultSrc=00, regWrite=1. Next: FETCH.
- MEM_ADR: A=A, B=Imm, ADD. Next: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: adrSrc=1, resultSrc=00. Next: MEM_WB.
- MEM_WB: resultSrc=01, regWrite=1. Next: FETCH.
- MEM_WRITE: adrSrc=1, resultSrc=00, memWrite=1. Next: FETCH.
- BRANCH: A=A, B=B, SUB, resultSrc=00. Next: FETCH.
  - beq(000): PCWrite=zero
  - bne(001): PCWrite=!zero
  - blt(100): PCWrite=neg
  - bge(101): PCWrite=!neg
- JAL: resultSrc=00, PCWrite=1. Next: LINK.
- JALR: A=A, B=Imm, ADD, resultSrc=10, PCWrite=1. Next: LINK. Target bit 0 is not cleared.
- LINK: A=OldPC, B=4, ADD, resultSrc=10, regWrite=1. Next: FETCH.
- LUI: resultSrc=11, regWrite=1. Next: FETCH.
- lw/sw func3 must be 010; any other value is illegal.
- Illegal instructions act as NOP: no register, memory or PC write beyond FETCH.

## Timing
- Reset:
  - While `rst`=1, all outputs are 0 and `illegal`=0.
  - On the edge with `rst`=1, state ← FETCH.
  - The first cycle after deassertion is FETCH.
- Reset mid-instruction aborts the instruction. No write enable is asserted in the reset cycle.
- Cycles per instruction:
  - R/I-ALU: 4
  - lw: 5
  - sw: 4
  - branch: 3
  - jal: 4
  - jalr: 4
  - lui: 3
  - illegal: 2
- In BRANCH, `zero`/`neg` are sampled in the same cycle; `PCWrite` is combinational from them.
- In JALR, PC is written before LINK writes rd, so rd == rs1 is safe.

## Test plan
- rst held 2 cycles, then released:
  - outputs are all 0 during reset;
  - cycle 1 after release shows IRWrite=1, PCWrite=1, ALUSrcB=10, resultSrc=10.
- add (op 0110011, func3 000, func7 0):
  - state sequence FETCH, DECODE, EX_R, ALU_WB;
  - ALUControl=000 in EX_R; regWrite=1 only in cycle 4.
- sub (func7 1): ALUControl=001. Repeat with func3 111 → 010 and func3 010 → 100.
- lw:
  - 5 cycles; adrSrc=1 in MEM_READ;
  - resultSrc=01 with regWrite=1 in MEM_WB; memWrite never 1.
- sw:
  - memWrite=1 exactly once, in cycle 4; immSrc=001;
  - regWrite never 1.
- Branches in the BRANCH cycle:
  - beq with zero=1 → PCWrite=1; with zero=0 → PCWrite=0;
  - blt with neg=1 → PCWrite=1; bge with neg=1 → PCWrite=0.
- jal: PCWrite=1 with resultSrc=00 in cycle 3, then regWrite=1 with ALUSrcA=01, ALUSrcB=10 in cycle 4.
- Illegal input op 1111111: illegal=1 in DECODE, next state FETCH, no regWrite or memWrite.
- rst asserted during MEM_ADR: next cycle is FETCH, and memWrite stays 0 throughout.

Source files
------------

// File: rtl/risc_v_multicycle_controller.sv
// Moore-style control FSM for the multi-cycle RISC-V datapath.
// Sequences each instruction and drives every datapath enable and mux select.
module risc_v_multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic       func7,
  input  logic       zero,
  input  logic       neg,
  output logic       PCWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       IRWrite,
  output logic       regWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] immSrc,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EX_R,
    S_EX_I,
    S_ALU_WB,
    S_MEM_ADR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LINK,
    S_LUI
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  state_t     r_state;
  state_t     w_next;
  logic       w_alu_f3_ok;
  logic       w_br_f3_ok;
  logic       w_mem_f3_ok;
  logic [2:0] w_alu_op;
  logic       w_br_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // func3 legality per instruction class, checked once in DECODE
  always_comb begin
    w_alu_f3_ok = (func3 == 3'b000) || (func3 == 3'b111) || (func3 == 3'b110) ||
                  (func3 == 3'b010) || (func3 == 3'b100);
    w_br_f3_ok  = (func3 == 3'b000) || (func3 == 3'b001) ||
                  (func3 == 3'b100) || (func3 == 3'b101);
    w_mem_f3_ok = (func3 == 3'b010);
  end

  // func7 only distinguishes SUB from ADD, and only for register-register ops
  always_comb begin
    w_alu_op = ALU_ADD;
    case (func3)
      3'b000:  w_alu_op = (r_state == S_EX_R && func7) ? ALU_SUB : ALU_ADD;
      3'b111:  w_alu_op = ALU_AND;
      3'b110:  w_alu_op = ALU_OR;
      3'b010:  w_alu_op = ALU_SLT;
      3'b100:  w_alu_op = ALU_XOR;
      default: w_alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    w_br_taken = 1'b0;
    case (func3)
      3'b000:  w_br_taken = zero;
      3'b001:  w_br_taken = !zero;
      3'b100:  w_br_taken = neg;
      3'b101:  w_br_taken = !neg;
      default: w_br_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next     = S_FETCH;
    PCWrite    = 1'b0;
    adrSrc     = 1'b0;
    memWrite   = 1'b0;
    IRWrite    = 1'b0;
    regWrite   = 1'b0;
    resultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    illegal    = 1'b0;

    case (op)
      OP_JALR, OP_LW, OP_I: immSrc = 3'b000;
      OP_SW:                immSrc = 3'b001;
      OP_BR:                immSrc = 3'b010;
      OP_LUI:               immSrc = 3'b011;
      OP_JAL:               immSrc = 3'b100;
      default:              immSrc = 3'b000;
    endcase

    case (r_state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        resultSrc = 2'b10;
        PCWrite   = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_R:          begin if (w_alu_f3_ok) w_next = S_EX_R;    else illegal = 1'b1; end
          OP_I:          begin if (w_alu_f3_ok) w_next = S_EX_I;    else illegal = 1'b1; end
          OP_LW, OP_SW:  begin if (w_mem_f3_ok) w_next = S_MEM_ADR; else illegal = 1'b1; end
          OP_BR:         begin if (w_br_f3_ok)  w_next = S_BRANCH;  else illegal = 1'b1; end
          OP_JAL:        w_next = S_JAL;
          OP_JALR:       w_next = S_JALR;
          OP_LUI:        w_next = S_LUI;
          default:       illegal = 1'b1;
        endcase
      end
      S_EX_R: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = w_alu_op;
        w_next     = S_ALU_WB;
      end
      S_EX_I: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = w_alu_op;
        w_next     = S_ALU_WB;
      end
      S_ALU_WB: begin
        regWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEM_ADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        // op[5] separates sw (0100011) from lw (0000011)
        w_next  = op[5] ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        adrSrc = 1'b1;
        w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEM_WRITE: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_SUB;
        PCWrite    = w_br_taken;
        w_next     = S_FETCH;
      end
      S_JAL: begin
        PCWrite = 1'b1;
        w_next  = S_LINK;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        resultSrc = 2'b10;
        PCWrite   = 1'b1;
        w_next    = S_LINK;
      end
      S_LINK: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        resultSrc = 2'b10;
        regWrite  = 1'b1;
        w_next    = S_FETCH;
      end
      S_LUI: begin
        resultSrc = 2'b11;
        regWrite  = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase

    // Reset silences every output so nothing is written in the reset cycle
    if (rst) begin
      PCWrite    = 1'b0;
      adrSrc     = 1'b0;
      memWrite   = 1'b0;
      IRWrite    = 1'b0;
      regWrite   = 1'b0;
      resultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
      immSrc     = 3'b000;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_risc_v_multicycle_controller.sv
// Directed bench for the multi-cycle controller: per-cycle output vectors per instruction.
module tb_risc_v_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'b0100011;
  logic [2:0] func3 = 3'b010;
  logic       func7 = 1'b0;
  logic       zero = 1'b0;
  logic       neg = 1'b0;
  logic       PCWrite, adrSrc, memWrite, IRWrite, regWrite, illegal;
  logic [1:0] resultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, immSrc;

  int errors = 0;
  int checks = 0;

  risc_v_multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
    .zero(zero), .neg(neg), .PCWrite(PCWrite), .adrSrc(adrSrc),
    .memWrite(memWrite), .IRWrite(IRWrite), .regWrite(regWrite),
    .resultSrc(resultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .immSrc(immSrc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {PCWrite, adrSrc, memWrite, IRWrite, regWrite, resultSrc, ALUSrcA, ALUSrcB, ALUControl, immSrc, illegal}
  logic [17:0] obs;
  assign obs = {PCWrite, adrSrc, memWrite, IRWrite, regWrite, resultSrc,
                ALUSrcA, ALUSrcB, ALUControl, immSrc, illegal};

  function automatic logic [17:0] vec(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic rw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] alu, input logic [2:0] imm,
                                      input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, ill};
  endfunction

  function automatic logic [17:0] fetch_v(input logic [2:0] imm);
    return vec(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0);
  endfunction

  function automatic logic [17:0] decode_v(input logic [2:0] imm);
    return vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] zero_v;
    zero_v = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== zero_v) begin
      $display("FAIL reset_outputs: got %b expected %b", obs, zero_v);
      errors++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== fetch_v(3'b001)) begin
      $display("FAIL reset_first_fetch: got %b expected %b", obs, fetch_v(3'b001));
      errors++;
    end
    $display("reset: held 2 cycles, released into FETCH");
  endtask

  task automatic test_alu();
    logic [6:0]  t_op  [0:7];
    logic [2:0]  t_f3  [0:7];
    logic        t_f7  [0:7];
    logic [2:0]  t_alu [0:7];
    logic [1:0]  t_sb  [0:7];
    logic [17:0] exp_v [0:3];
    t_op[0] = 7'b0110011; t_f3[0] = 3'b000; t_f7[0] = 0; t_alu[0] = 3'b000; t_sb[0] = 2'b00;
    t_op[1] = 7'b0110011; t_f3[1] = 3'b000; t_f7[1] = 1; t_alu[1] = 3'b001; t_sb[1] = 2'b00;
    t_op[2] = 7'b0110011; t_f3[2] = 3'b111; t_f7[2] = 0; t_alu[2] = 3'b010; t_sb[2] = 2'b00;
    t_op[3] = 7'b0110011; t_f3[3] = 3'b010; t_f7[3] = 0; t_alu[3] = 3'b100; t_sb[3] = 2'b00;
    t_op[4] = 7'b0110011; t_f3[4] = 3'b110; t_f7[4] = 0; t_alu[4] = 3'b011; t_sb[4] = 2'b00;
    t_op[5] = 7'b0110011; t_f3[5] = 3'b100; t_f7[5] = 0; t_alu[5] = 3'b101; t_sb[5] = 2'b00;
    t_op[6] = 7'b0010011; t_f3[6] = 3'b000; t_f7[6] = 1; t_alu[6] = 3'b000; t_sb[6] = 2'b01;
    t_op[7] = 7'b0010011; t_f3[7] = 3'b110; t_f7[7] = 1; t_alu[7] = 3'b011; t_sb[7] = 2'b01;
    for (int t = 0; t < 8; t++) begin
      op = t_op[t]; func3 = t_f3[t]; func7 = t_f7[t];
      #1;
      exp_v[0] = fetch_v(3'b000);
      exp_v[1] = decode_v(3'b000);
      exp_v[2] = vec(0, 0, 0, 0, 0, 2'b00, 2'b10, t_sb[t], t_alu[t], 3'b000, 0);
      exp_v[3] = vec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (obs !== exp_v[c]) begin
          $display("FAIL alu[%0d] cycle %0d: got %b expected %b", t, c, obs, exp_v[c]);
          errors++;
        end
        step();
      end
      $display("alu: op=%b f3=%b f7=%b expected ALUControl=%b", t_op[t], t_f3[t], t_f7[t], t_alu[t]);
    end
  endtask

  task automatic test_load_store();
    logic [17:0] exp_v [0:4];
    op = 7'b0000011; func3 = 3'b010; func7 = 0;
    #1;
    exp_v[0] = fetch_v(3'b000);
    exp_v[1] = decode_v(3'b000);
    exp_v[2] = vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0);
    exp_v[3] = vec(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
    exp_v[4] = vec(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (obs !== exp_v[c]) begin
        $display("FAIL lw cycle %0d: got %b expected %b", c, obs, exp_v[c]);
        errors++;
      end
      step();
    end
    $display("lw: 5 cycles");
    op = 7'b0100011;
    #1;
    exp_v[0] = fetch_v(3'b001);
    exp_v[1] = decode_v(3'b001);
    exp_v[2] = vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0);
    exp_v[3] = vec(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs !== exp_v[c]) begin
        $display("FAIL sw cycle %0d: got %b expected %b", c, obs, exp_v[c]);
        errors++;
      end
      step();
    end
    $display("sw: 4 cycles");
  endtask

  task automatic test_branch();
    logic [2:0] t_f3 [0:5];
    logic       t_z  [0:5];
    logic       t_n  [0:5];
    logic       t_pc [0:5];
    logic [17:0] exp_v [0:2];
    t_f3[0] = 3'b000; t_z[0] = 1; t_n[0] = 0; t_pc[0] = 1;
    t_f3[1] = 3'b000; t_z[1] = 0; t_n[1] = 0; t_pc[1] = 0;
    t_f3[2] = 3'b100; t_z[2] = 0; t_n[2] = 1; t_pc[2] = 1;
    t_f3[3] = 3'b101; t_z[3] = 0; t_n[3] = 1; t_pc[3] = 0;
    t_f3[4] = 3'b001; t_z[4] = 0; t_n[4] = 0; t_pc[4] = 1;
    t_f3[5] = 3'b101; t_z[5] = 1; t_n[5] = 0; t_pc[5] = 1;
    for (int t = 0; t < 6; t++) begin
      op = 7'b1100011; func3 = t_f3[t]; zero = t_z[t]; neg = t_n[t];
      #1;
      exp_v[0] = fetch_v(3'b010);
      exp_v[1] = decode_v(3'b010);
      exp_v[2] = vec(t_pc[t], 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (obs !== exp_v[c]) begin
          $display("FAIL branch[%0d] cycle %0d: got %b expected %b", t, c, obs, exp_v[c]);
          errors++;
        end
        step();
      end
      $display("branch: f3=%b zero=%b neg=%b expected PCWrite=%b", t_f3[t], t_z[t], t_n[t], t_pc[t]);
    end
    zero = 0; neg = 0;
  endtask

  task automatic test_jumps();
    logic [17:0] exp_v [0:3];
    logic [17:0] link_v;
    link_v = vec(0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 3'b000, 3'b000, 0);
    op = 7'b1101111; func3 = 3'b000;
    #1;
    exp_v[0] = fetch_v(3'b100);
    exp_v[1] = decode_v(3'b100);
    exp_v[2] = vec(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b100, 0);
    exp_v[3] = link_v | 18'b000000000000001000;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs !== exp_v[c]) begin
        $display("FAIL jal cycle %0d: got %b expected %b", c, obs, exp_v[c]);
        errors++;
      end
      step();
    end
    $display("jal: 4 cycles");
    op = 7'b1100111;
    #1;
    exp_v[0] = fetch_v(3'b000);
    exp_v[1] = decode_v(3'b000);
    exp_v[2] = vec(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 3'b000, 3'b000, 0);
    exp_v[3] = link_v;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs !== exp_v[c]) begin
        $display("FAIL jalr cycle %0d: got %b expected %b", c, obs, exp_v[c]);
        errors++;
      end
      step();
    end
    $display("jalr: 4 cycles");
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp_v [0:2];
    for (int t = 0; t < 2; t++) begin
      op = 7'b0110111; func3 = 3'(t * 5);
      #1;
      exp_v[0] = fetch_v(3'b011);
      exp_v[1] = decode_v(3'b011);
      exp_v[2] = vec(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, 3'b011, 0);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (obs !== exp_v[c]) begin
          $display("FAIL lui[%0d] cycle %0d: got %b expected %b", t, c, obs, exp_v[c]);
          errors++;
        end
        step();
      end
      $display("lui[%0d]: 3 cycles", t);
    end
  endtask

  task automatic test_illegal();
    logic [6:0] t_op [0:3];
    logic [2:0] t_f3 [0:3];
    logic [17:0] exp_v [0:2];
    t_op[0] = 7'b1111111; t_f3[0] = 3'b000;
    t_op[1] = 7'b0110011; t_f3[1] = 3'b001;
    t_op[2] = 7'b0000011; t_f3[2] = 3'b000;
    t_op[3] = 7'b1100011; t_f3[3] = 3'b010;
    for (int t = 0; t < 4; t++) begin
      op = t_op[t]; func3 = t_f3[t]; func7 = 0;
      #1;
      exp_v[0] = fetch_v(t == 3 ? 3'b010 : 3'b000);
      exp_v[1] = vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000,
                     t == 3 ? 3'b010 : 3'b000, 1);
      exp_v[2] = exp_v[0];
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (obs !== exp_v[c]) begin
          $display("FAIL illegal[%0d] cycle %0d: got %b expected %b", t, c, obs, exp_v[c]);
          errors++;
        end
        if (c < 2) step();
      end
      $display("illegal: op=%b f3=%b", t_op[t], t_f3[t]);
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] exp_v [0:3];
    logic [17:0] zero_v;
    zero_v = '0;
    op = 7'b0100011; func3 = 3'b010;
    #1;
    exp_v[0] = fetch_v(3'b001);
    exp_v[1] = decode_v(3'b001);
    exp_v[2] = vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0);
    exp_v[3] = vec(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs !== exp_v[c]) begin
        $display("FAIL rst_mid pre cycle %0d: got %b expected %b", c, obs, exp_v[c]);
        errors++;
      end
      if (c < 2) step();
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== zero_v) begin
      $display("FAIL rst_mid asserted: got %b expected %b", obs, zero_v);
      errors++;
    end
    step();
    rst = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs !== exp_v[c]) begin
        $display("FAIL rst_mid post cycle %0d: got %b expected %b", c, obs, exp_v[c]);
        errors++;
      end
      step();
    end
    $display("rst_mid: sw aborted in MEM_ADR then rerun");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_jumps();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
